// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: valid/ready handshake, load-use bubble
// insertion, branch flush, capture-time MEM/WB bypass and EX/MEM + MEM/WB output forwarding.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_uses_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rdata1,
  input  logic [DATA_W-1:0] in_rdata2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [3:0]        in_aluop,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              flush,
  input  logic              out_ready,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_read,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_regA,
  output logic [DATA_W-1:0] out_regB,
  output logic [DATA_W-1:0] out_store_data,
  output logic [3:0]        out_aluop,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [3:0]        aluop_q, aluop_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic              hz;
  logic              capture;
  logic [DATA_W-1:0] cap_data1;
  logic [DATA_W-1:0] cap_data2;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  assign hz = in_valid & valid_q & mem_read_q & (rd_q != '0) &
              ((rd_q == in_rs1) | (in_uses_rs2 & (rd_q == in_rs2)));
  assign in_ready = (~valid_q | out_ready) & ~hz & ~flush;
  assign capture  = in_valid & in_ready;

  // A write-back landing in the same cycle as the register-file read wins over the stale read data.
  always_comb begin
    cap_data1 = in_rdata1;
    cap_data2 = in_rdata2;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == in_rs1)) cap_data1 = memwb_result;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == in_rs2)) cap_data2 = memwb_result;
  end

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    aluop_d     = aluop_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      rs1_d       = in_rs1;
      rs2_d       = in_rs2;
      rd_d        = in_rd;
      rdata1_d    = cap_data1;
      rdata2_d    = cap_data2;
      imm_d       = in_imm;
      use_imm_d   = in_use_imm;
      aluop_d     = in_aluop;
      reg_write_d = in_reg_write;
      mem_read_d  = in_mem_read;
      mem_write_d = in_mem_write;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      aluop_q     <= 4'b0000;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      aluop_q     <= aluop_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet, and r0 never forwards.
  always_comb begin
    fwd_rs1 = rdata1_q;
    if (exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rs1_q))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q))
      fwd_rs1 = memwb_result;

    fwd_rs2 = rdata2_q;
    if (exmem_reg_write && !exmem_mem_read && (exmem_rd != '0) && (exmem_rd == rs2_q))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q))
      fwd_rs2 = memwb_result;
  end

  assign out_valid      = valid_q;
  assign out_regA       = fwd_rs1;
  assign out_regB       = use_imm_q ? imm_q : fwd_rs2;
  assign out_store_data = fwd_rs2;
  assign out_aluop      = aluop_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = valid_q & reg_write_q;
  assign out_mem_read   = valid_q & mem_read_q;
  assign out_mem_write  = valid_q & mem_write_q;

endmodule
